instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Instruction fetch front end. Walks a program counter through a
//   synchronous-read instruction memory, captures each returned word, and
//   buffers up to two {instr, pc} pairs for a downstream decoder using a
//   valid/ready handshake. A branch/jump redirect flushes everything in
//   flight and restarts fetching at the new address.
//
// Parameters:
//   ADDR_W    instruction address width (memory depth 2^ADDR_W words)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   en              fetch enable; low only blocks new fetches
//   redirect_valid  redirect request, overrides push/pop/issue
//   redirect_addr   new fetch address
//   imem_addr       address to instruction memory (always the pc register)
//   imem_rd         registered memory read data, valid one cycle after address
//   instr_valid     instr/instr_pc hold a fetched instruction
//   instr_ready     decoder accepts the instruction this cycle
//   instr           fetched instruction (0 when nothing buffered)
//   instr_pc        address the instruction came from (0 when nothing buffered)
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W   = 3,
  parameter int RESET_PC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rd,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_pc;
  entry_t            fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        outstanding;

  // Handshake and credit logic. A new fetch is only issued when the
  // instructions already buffered plus the one in flight, minus the one
  // leaving this cycle, leave room in the two-entry buffer. This makes a
  // push into a full buffer impossible, so no overflow handling is needed.
  always_comb begin
    pop         = (count != 2'd0) & instr_ready;
    push        = pend_v & ~redirect_valid;
    outstanding = {1'b0, count} + {2'b00, pend_v} - {2'b00, pop};
    issue       = en & ~redirect_valid & (outstanding < 3'd2);
  end

  assign imem_addr   = pc;
  assign instr_valid = (count != 2'd0);

  // Head of the buffer is presented directly; forced to zero when empty so
  // stale storage left behind by a flush never leaks onto the outputs.
  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (count != 2'd0) begin
      instr    = fifo_mem[rd_ptr].instr;
      instr_pc = fifo_mem[rd_ptr].pc;
    end
  end

  // All state lives in one register block. Priority is reset, then
  // redirect (which discards the in-flight fetch and flushes the buffer),
  // then normal operation where issue, push and pop may all happen on the
  // same edge. The word on imem_rd always belongs to pend_pc because the
  // memory registers the address on the issue edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_ADDR;
      pend_v      <= 1'b0;
      pend_pc     <= '0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_addr;
      pend_v <= 1'b0;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (issue) begin
        pc      <= pc + ADDR_W'(1);
        pend_v  <= 1'b1;
        pend_pc <= pc;
      end else begin
        pend_v  <= 1'b0;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= '{instr: imem_rd, pc: pend_pc};
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A synchronous-read memory model
// returns a distinct word per address. A queue-based model of the fetch
// stream (next address, fetch in flight, buffered pcs) predicts the DUT
// outputs, and one compare process checks them on every falling edge.
// Directed sequences pin the model with hand-computed literals, then
// randomized traffic exercises enable, ready, redirect and reset.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W   = 3;
  localparam int RESET_PC = 1;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rd;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;

  int total;
  int bad;

  // Model state: next address to fetch, fetch in flight, buffered pcs.
  int m_pc;
  int m_inflight[$];
  int m_buf[$];
  bit model_on;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory: a distinct word at every address.
  function automatic logic [31:0] mem_word(input int a);
    return 32'hC0DE_0000 | (32'(a) * 32'h0000_0111);
  endfunction

  // Synchronous-read memory: data for an address arrives one cycle later.
  always @(posedge clk) imem_rd <= mem_word(int'(imem_addr));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic rv,
                               input logic [ADDR_W-1:0] ra, input logic rdy);
    rst            = r;
    en             = e;
    redirect_valid = rv;
    redirect_addr  = ra;
    instr_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model of the fetch stream, advanced on each rising edge.
  always @(posedge clk) begin
    bit pop;
    bit do_issue;
    int outstanding;
    if (rst) begin
      m_pc = RESET_PC;
      m_inflight.delete();
      m_buf.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      if (redirect_valid) begin
        m_inflight.delete();
        m_buf.delete();
        m_pc = int'(redirect_addr);
      end else begin
        pop         = (m_buf.size() > 0) && instr_ready;
        outstanding = m_buf.size() + m_inflight.size() - int'(pop);
        do_issue    = en && (outstanding < 2);
        if (pop) void'(m_buf.pop_front());
        if (m_inflight.size() > 0) begin
          if (m_buf.size() >= 2) begin
            bad++;
            $display("[TB] FAIL overflow: push into buffer holding %0d, limit 2", m_buf.size());
          end
          m_buf.push_back(m_inflight.pop_front());
        end
        if (do_issue) begin
          m_inflight.push_back(m_pc);
          m_pc = (m_pc + 1) % DEPTH;
        end
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("imem_addr", 32'(imem_addr), 32'(m_pc));
      checkOutput("instr_valid", 32'(instr_valid), 32'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        checkOutput("instr_pc", 32'(instr_pc), 32'(m_buf[0]));
        checkOutput("instr", instr, mem_word(m_buf[0]));
      end else begin
        checkOutput("instr_pc_idle", 32'(instr_pc), 32'd0);
        checkOutput("instr_idle", instr, 32'd0);
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq_a[8];
    int next_exp;
    logic rdy;
    logic e;

    total          = 0;
    bad            = 0;
    model_on       = 1'b0;
    rst            = 1'b0;
    en             = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    instr_ready    = 1'b0;

    // Reset state, then a free-running stream across the address wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd1);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_instr_pc", 32'(instr_pc), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("first_cycle_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("first_valid", 32'(instr_valid), 32'd1);
    checkOutput("first_pc", 32'(instr_pc), 32'd1);
    checkOutput("first_instr", instr, 32'hC0DE_0111);

    seq_a = '{2, 3, 4, 5, 6, 7, 0, 1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
      checkOutput("stream_pc", 32'(instr_pc), 32'(seq_a[i]));
    end

    // Backpressure: buffer fills, fetch address stops two past the head.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("stall_head", 32'(instr_pc), 32'd1);
    checkOutput("stall_addr", 32'(imem_addr), 32'd3);
    checkOutput("stall_valid", 32'(instr_valid), 32'd1);

    // Drain in order.
    seq_a = '{2, 3, 4, 5, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
      checkOutput("drain_pc", 32'(instr_pc), 32'(seq_a[i]));
    end

    // Redirect to 3 while 5 is buffered and 6 is in flight.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    checkOutput("redir_valid", 32'(instr_valid), 32'd0);
    checkOutput("redir_addr", 32'(imem_addr), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("redir_issue_valid", 32'(instr_valid), 32'd0);

    // Enable drops with the fetch of 3 in flight: it still lands and holds.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      checkOutput("hold_pc", 32'(instr_pc), 32'd3);
      checkOutput("hold_addr", 32'(imem_addr), 32'd4);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("resume_addr", 32'(imem_addr), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("resume_pc", 32'(instr_pc), 32'd4);

    // Fill the buffer, then reset together with a redirect.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 1'b1);
    checkOutput("rst_redir_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_redir_addr", 32'(imem_addr), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("post_rst_pc", 32'(instr_pc), 32'd1);
    checkOutput("post_rst_instr", instr, 32'hC0DE_0111);

    // Random enable, ready toggling every cycle: delivery stays consecutive.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    next_exp = RESET_PC;
    for (int i = 0; i < 300; i++) begin
      rdy = 1'(i % 2);
      e   = ($urandom_range(0, 3) != 0);
      if (instr_valid && rdy) begin
        checkOutput("consecutive_pc", 32'(instr_pc), 32'(next_exp));
        next_exp = (next_exp + 1) % DEPTH;
      end
      applyStimulus(1'b0, e, 1'b0, 3'd0, rdy);
    end

    // Fully random traffic including redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0),
                    3'($urandom_range(0, DEPTH - 1)),
                    1'($urandom_range(0, 1)));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
